// File: rtl/pq_pkg.sv
// Shared types and helpers for the sorted-array priority queue.
//   pq_op_e      : operation encoding presented on op_i
//   slot_sel_e   : per-slot next-state source chosen by the top-level controller
//   time_before(): wrap-aware ordering of time keys of any width up to MaxTimeW
package pq_pkg;

  typedef enum logic [2:0] {
    PQ_NOP     = 3'd0,
    PQ_PUSH    = 3'd1,
    PQ_POP     = 3'd2,
    PQ_REPLACE = 3'd3,
    PQ_DROP_ID = 3'd4,
    PQ_FLUSH   = 3'd5
  } pq_op_e;

  // Legacy generic types kept for existing users.
  typedef logic [2:0] op_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] key;
  } cell_t;

  // Where a slot takes its next value from.
  typedef enum logic [2:0] {
    SelHold  = 3'd0,
    SelNew   = 3'd1,
    SelLeft  = 3'd2,  // slot k-1 (shift toward tail)
    SelRight = 3'd3,  // slot k+1 (shift toward head)
    SelClear = 3'd4
  } slot_sel_e;

  localparam int unsigned MaxTimeW = 64;

  // True when a precedes b modulo 2**time_w. Callers zero-extend their keys; the low time_w
  // bits of the wide difference equal the modular difference, so its bit time_w-1 is the answer.
  function automatic logic time_before(input logic [MaxTimeW-1:0] a,
                                       input logic [MaxTimeW-1:0] b,
                                       input int unsigned         time_w);
    logic [MaxTimeW-1:0] diff;
    logic [5:0]          msb;
    diff = a - b;
    msb  = 6'(time_w - 1);
    return diff[msb];
  endfunction

endpackage

// File: rtl/pq_slot.sv
// One storage slot of the sorted-array priority queue.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   sel_i         : next-state source (hold / new entry / left / right neighbour / clear)
//   new_i         : entry being inserted this cycle
//   left_i        : contents of slot k-1 (zero for slot 0)
//   right_i       : contents of slot k+1 (zero for the last slot)
//   time_i, id_i  : operation key and id for the local compares
//   entry_o       : current slot contents {valid, time, id, payload}
//   ins_hit_o     : slot is empty or time_i precedes the stored key
//   id_hit_o      : slot is valid and holds id_i
module pq_slot
  import pq_pkg::*;
#(
  parameter int unsigned TIME_W    = 27,
  parameter int unsigned ID_W      = 27,
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  slot_sel_e                       sel_i,
  input  logic [TIME_W+ID_W+PAYLOAD_W:0]  new_i,
  input  logic [TIME_W+ID_W+PAYLOAD_W:0]  left_i,
  input  logic [TIME_W+ID_W+PAYLOAD_W:0]  right_i,
  input  logic [TIME_W-1:0]               time_i,
  input  logic [ID_W-1:0]                 id_i,
  output logic [TIME_W+ID_W+PAYLOAD_W:0]  entry_o,
  output logic                            ins_hit_o,
  output logic                            id_hit_o
);

  typedef struct packed {
    logic                 valid;
    logic [TIME_W-1:0]    t;
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    unique case (sel_i)
      SelHold:  entry_d = entry_q;
      SelNew:   entry_d = new_i;
      SelLeft:  entry_d = left_i;
      SelRight: entry_d = right_i;
      SelClear: entry_d = '0;
      default:  entry_d = entry_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o   = entry_q;
  // Strict compare: an equal key does not hit, so new equals land behind existing ones.
  assign ins_hit_o = !entry_q.valid ||
                     time_before(MaxTimeW'(time_i), MaxTimeW'(entry_q.t), TIME_W);
  assign id_hit_o  = entry_q.valid && (entry_q.id == id_i);

endmodule

// File: rtl/pq_sorted_array.sv
// Shift-register priority queue for timer events, sorted by wrap-aware time key.
// One operation per cycle (push, pop, replace, drop-by-id, flush), no stalls.
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   op_valid_i, op_i           : operation request and code (pq_op_e)
//   time_i, id_i, payload_i    : new entry for PUSH/REPLACE; id_i is the DROP_ID key
//   now_i                      : current time, used only for due_o
//   head_valid_o, head_*_o     : slot 0 contents (zero when empty)
//   due_o                      : head is valid and its time has been reached
//   count_o, full_o, empty_o   : occupancy
//   evict_valid_o, evict_*_o   : one-cycle pulse with a displaced or rejected entry
//   drop_hit_o                 : one-cycle pulse when DROP_ID removed an entry
module pq_sorted_array
  import pq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TIME_W    = 27,
  parameter int unsigned ID_W      = 27,
  parameter int unsigned PAYLOAD_W = 8,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 op_valid_i,
  input  pq_op_e               op_i,
  input  logic [TIME_W-1:0]    time_i,
  input  logic [ID_W-1:0]      id_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [TIME_W-1:0]    now_i,
  output logic                 head_valid_o,
  output logic [TIME_W-1:0]    head_time_o,
  output logic [ID_W-1:0]      head_id_o,
  output logic [PAYLOAD_W-1:0] head_payload_o,
  output logic                 due_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 evict_valid_o,
  output logic [TIME_W-1:0]    evict_time_o,
  output logic [ID_W-1:0]      evict_id_o,
  output logic [PAYLOAD_W-1:0] evict_payload_o,
  output logic                 drop_hit_o
);

  localparam int unsigned EntryW = 1 + TIME_W + ID_W + PAYLOAD_W;

  typedef struct packed {
    logic                 valid;
    logic [TIME_W-1:0]    t;
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  logic [EntryW-1:0] slot_q [DEPTH];
  slot_sel_e         slot_sel [DEPTH];
  logic [DEPTH-1:0]  ins_vec;
  logic [DEPTH-1:0]  id_vec;

  logic [CNT_W-1:0] count_q, count_d;
  logic             evict_valid_q, evict_valid_d;
  entry_t           evict_q, evict_d;
  logic             drop_hit_q, drop_hit_d;

  entry_t      head, new_entry;
  pq_op_e      op_eff;
  logic        full, empty;
  int unsigned push_pos, repl_pos, drop_pos;
  logic        push_found, drop_found;

  assign new_entry = '{valid: 1'b1, t: time_i, id: id_i, payload: payload_i};
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Slot array
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic [EntryW-1:0] left, right;
    if (k == 0) begin : g_first
      assign left = '0;
    end else begin : g_mid_l
      assign left = slot_q[k-1];
    end
    if (k == DEPTH - 1) begin : g_last
      assign right = '0;
    end else begin : g_mid_r
      assign right = slot_q[k+1];
    end

    pq_slot #(
      .TIME_W    (TIME_W),
      .ID_W      (ID_W),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .sel_i     (slot_sel[k]),
      .new_i     (new_entry),
      .left_i    (left),
      .right_i   (right),
      .time_i    (time_i),
      .id_i      (id_i),
      .entry_o   (slot_q[k]),
      .ins_hit_o (ins_vec[k]),
      .id_hit_o  (id_vec[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Index search: first insert position, first insert position past the head
  // (for REPLACE, where the head leaves in the same cycle) and first id match.
  // ---------------------------------------------------------------------------
  always_comb begin
    push_pos   = DEPTH;
    push_found = 1'b0;
    repl_pos   = DEPTH;
    drop_pos   = DEPTH;
    drop_found = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ins_vec[k] && !push_found) begin
        push_pos   = k;
        push_found = 1'b1;
      end
      if (id_vec[k] && !drop_found) begin
        drop_pos   = k;
        drop_found = 1'b1;
      end
    end
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (ins_vec[k]) begin
        repl_pos = k;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operation decode and slot control
  // ---------------------------------------------------------------------------
  always_comb begin
    op_eff = PQ_NOP;
    if (op_valid_i) begin
      case (op_i)
        PQ_PUSH, PQ_POP, PQ_REPLACE, PQ_DROP_ID, PQ_FLUSH: op_eff = op_i;
        default:                                           op_eff = PQ_NOP;
      endcase
    end
    if (op_eff == PQ_REPLACE && empty) begin
      op_eff = PQ_PUSH;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot_sel[k] = SelHold;
    end
    count_d       = count_q;
    evict_valid_d = 1'b0;
    evict_d       = evict_q;
    drop_hit_d    = 1'b0;

    unique case (op_eff)
      PQ_PUSH: begin
        if (full && !push_found) begin
          // New entry sorts after every stored one: reject it.
          evict_valid_d = 1'b1;
          evict_d       = new_entry;
        end else begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            if (k == push_pos) begin
              slot_sel[k] = SelNew;
            end else if (k > push_pos) begin
              slot_sel[k] = SelLeft;
            end
          end
          if (full) begin
            evict_valid_d = 1'b1;
            evict_d       = slot_q[DEPTH-1];
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      PQ_POP: begin
        if (!empty) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            slot_sel[k] = SelRight;
          end
          count_d = count_q - CNT_W'(1);
        end
      end
      PQ_REPLACE: begin
        // Slots ahead of the insert point move toward the head to fill the vacated slot 0.
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (k + 1 < repl_pos) begin
            slot_sel[k] = SelRight;
          end else if (k + 1 == repl_pos) begin
            slot_sel[k] = SelNew;
          end
        end
      end
      PQ_DROP_ID: begin
        if (drop_found) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            if (k >= drop_pos) begin
              slot_sel[k] = SelRight;
            end
          end
          count_d    = count_q - CNT_W'(1);
          drop_hit_d = 1'b1;
        end
      end
      PQ_FLUSH: begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          slot_sel[k] = SelClear;
        end
        count_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q       <= '0;
      evict_valid_q <= 1'b0;
      evict_q       <= '0;
      drop_hit_q    <= 1'b0;
    end else begin
      count_q       <= count_d;
      evict_valid_q <= evict_valid_d;
      evict_q       <= evict_d;
      drop_hit_q    <= drop_hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head = slot_q[0];

  // Vacated slots may carry stale fields; present zeros whenever the head is empty.
  assign head_valid_o   = head.valid;
  assign head_time_o    = head.valid ? head.t : '0;
  assign head_id_o      = head.valid ? head.id : '0;
  assign head_payload_o = head.valid ? head.payload : '0;
  assign due_o          = head.valid &&
                          !time_before(MaxTimeW'(now_i), MaxTimeW'(head.t), TIME_W);

  assign count_o         = count_q;
  assign full_o          = full;
  assign empty_o         = empty;
  assign evict_valid_o   = evict_valid_q;
  assign evict_time_o    = evict_q.t;
  assign evict_id_o      = evict_q.id;
  assign evict_payload_o = evict_q.payload;
  assign drop_hit_o      = drop_hit_q;

endmodule

// File: tb/tb_pq_sorted_array.sv
// Directed bench for pq_sorted_array (DEPTH=4, 8-bit time/id/payload) plus a short
// pseudo-random operation stream checked against a behavioural queue model.
module tb_pq_sorted_array;
  import pq_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  pq_op_e     op;
  logic [7:0] time_in, id_in, payload_in, now_in;
  logic       head_valid, due, full, empty, evict_valid, drop_hit;
  logic [7:0] head_time, head_id, head_payload;
  logic [7:0] evict_time, evict_id, evict_payload;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  pq_sorted_array #(
    .DEPTH     (DEPTH),
    .TIME_W    (8),
    .ID_W      (8),
    .PAYLOAD_W (8)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .op_valid_i      (op_valid),
    .op_i            (op),
    .time_i          (time_in),
    .id_i            (id_in),
    .payload_i       (payload_in),
    .now_i           (now_in),
    .head_valid_o    (head_valid),
    .head_time_o     (head_time),
    .head_id_o       (head_id),
    .head_payload_o  (head_payload),
    .due_o           (due),
    .count_o         (count),
    .full_o          (full),
    .empty_o         (empty),
    .evict_valid_o   (evict_valid),
    .evict_time_o    (evict_time),
    .evict_id_o      (evict_id),
    .evict_payload_o (evict_payload),
    .drop_hit_o      (drop_hit)
  );

  always #5 clk = ~clk;

  // Present one op for one cycle; returns 1 time unit after the accepting edge.
  task automatic do_op(input pq_op_e o, input logic [7:0] t, input logic [7:0] i,
                       input logic [7:0] p);
    @(negedge clk);
    op_valid   = 1'b1;
    op         = o;
    time_in    = t;
    id_in      = i;
    payload_in = p;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = PQ_NOP;
  endtask

  function automatic logic before8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return d[7];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op = PQ_NOP;
    time_in = '0; id_in = '0; payload_in = '0; now_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++;
      $display("FAIL reset_occupancy: got cnt=%0d empty=%b full=%b want 0/1/0", count, empty, full);
    end
    n_checks++;
    if ({head_valid, head_time, head_id, head_payload, due} !== '0 ||
        {evict_valid, evict_time, evict_id, evict_payload, drop_hit} !== '0) begin n_fail++;
      $display("FAIL reset_outputs: got head_v=%b ev_v=%b hit=%b due=%b want all 0",
               head_valid, evict_valid, drop_hit, due);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(PQ_PUSH, 8'd5, 8'd1, 8'd0);
    do_op(PQ_PUSH, 8'd6, 8'd2, 8'd0);
    do_op(PQ_PUSH, 8'd7, 8'd3, 8'd0);
    n_checks++; if (count !== 3'd3) begin n_fail++;
      $display("FAIL pre_reset_count: got %0d want 3", count);
    end
    @(negedge clk); #2; rst_n = 1'b0; #1;
    n_checks++; if (empty !== 1'b1 || count !== 3'd0 || head_valid !== 1'b0) begin n_fail++;
      $display("FAIL async_reset: got empty=%b cnt=%0d head_v=%b want 1/0/0",
               empty, count, head_valid);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sorted_push_pop();
    logic [7:0] exp_t [4];
    logic [7:0] exp_i [4];
    exp_t = '{8'd10, 8'd10, 8'd20, 8'd30};
    exp_i = '{8'd2, 8'd7, 8'd3, 8'd1};
    do_op(PQ_PUSH, 8'd30, 8'd1, 8'd101);
    do_op(PQ_PUSH, 8'd10, 8'd2, 8'd102);
    do_op(PQ_PUSH, 8'd20, 8'd3, 8'd103);
    do_op(PQ_PUSH, 8'd10, 8'd7, 8'd107);
    n_checks++; if (count !== 3'd4 || full !== 1'b1 || evict_valid !== 1'b0) begin n_fail++;
      $display("FAIL sort_fill: got cnt=%0d full=%b ev=%b want 4/1/0", count, full, evict_valid);
    end
    n_checks++; if (head_payload !== 8'd102) begin n_fail++;
      $display("FAIL sort_payload: got %0d want 102", head_payload);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (head_time !== exp_t[k] || head_id !== exp_i[k]) begin n_fail++;
        $display("FAIL sort_pop%0d: got t=%0d id=%0d want t=%0d id=%0d",
                 k, head_time, head_id, exp_t[k], exp_i[k]);
      end
      do_op(PQ_POP, 8'd0, 8'd0, 8'd0);
    end
    n_checks++; if (empty !== 1'b1 || head_valid !== 1'b0) begin n_fail++;
      $display("FAIL sort_drain: got empty=%b head_v=%b want 1/0", empty, head_valid);
    end
  endtask

  task automatic test_wrap();
    do_op(PQ_PUSH, 8'd250, 8'd1, 8'd0);
    do_op(PQ_PUSH, 8'd5, 8'd2, 8'd0);
    n_checks++; if (head_time !== 8'd250 || head_id !== 8'd1) begin n_fail++;
      $display("FAIL wrap_head: got t=%0d id=%0d want 250/1", head_time, head_id);
    end
    now_in = 8'd249; #1;
    n_checks++; if (due !== 1'b0) begin n_fail++;
      $display("FAIL wrap_due_249: got %b want 0", due);
    end
    now_in = 8'd250; #1;
    n_checks++; if (due !== 1'b1) begin n_fail++;
      $display("FAIL wrap_due_250: got %b want 1", due);
    end
    now_in = 8'd2; #1;
    n_checks++; if (due !== 1'b1) begin n_fail++;
      $display("FAIL wrap_due_2: got %b want 1", due);
    end
    do_op(PQ_POP, 8'd0, 8'd0, 8'd0);
    n_checks++; if (head_time !== 8'd5 || due !== 1'b0) begin n_fail++;
      $display("FAIL wrap_second: got t=%0d due=%b want 5/0", head_time, due);
    end
    now_in = 8'd0;
    do_op(PQ_FLUSH, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_full_evict();
    do_op(PQ_PUSH, 8'd10, 8'd1, 8'd0);
    do_op(PQ_PUSH, 8'd20, 8'd2, 8'd0);
    do_op(PQ_PUSH, 8'd30, 8'd3, 8'd0);
    do_op(PQ_PUSH, 8'd40, 8'd4, 8'd44);
    do_op(PQ_PUSH, 8'd25, 8'd5, 8'd55);
    n_checks++;
    if (evict_valid !== 1'b1 || evict_time !== 8'd40 || evict_id !== 8'd4 ||
        evict_payload !== 8'd44 || count !== 3'd4) begin n_fail++;
      $display("FAIL evict_tail: got v=%b t=%0d id=%0d p=%0d cnt=%0d want 1/40/4/44/4",
               evict_valid, evict_time, evict_id, evict_payload, count);
    end
    do_op(PQ_NOP, 8'd0, 8'd0, 8'd0);
    n_checks++; if (evict_valid !== 1'b0) begin n_fail++;
      $display("FAIL evict_pulse_width: got %b want 0", evict_valid);
    end
    do_op(PQ_PUSH, 8'd50, 8'd6, 8'd66);
    n_checks++;
    if (evict_valid !== 1'b1 || evict_time !== 8'd50 || evict_id !== 8'd6 ||
        count !== 3'd4 || head_time !== 8'd10) begin n_fail++;
      $display("FAIL evict_reject: got v=%b t=%0d id=%0d cnt=%0d head=%0d want 1/50/6/4/10",
               evict_valid, evict_time, evict_id, count, head_time);
    end
  endtask

  task automatic test_replace_drop();
    logic [7:0] exp_t [3];
    exp_t = '{8'd15, 8'd20, 8'd30};
    do_op(PQ_REPLACE, 8'd15, 8'd8, 8'd0);
    n_checks++;
    if (head_time !== 8'd15 || head_id !== 8'd8 || count !== 3'd4 || evict_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL replace: got t=%0d id=%0d cnt=%0d ev=%b want 15/8/4/0",
               head_time, head_id, count, evict_valid);
    end
    do_op(PQ_DROP_ID, 8'd0, 8'd5, 8'd0);
    n_checks++; if (drop_hit !== 1'b1 || count !== 3'd3) begin n_fail++;
      $display("FAIL drop_hit: got hit=%b cnt=%0d want 1/3", drop_hit, count);
    end
    do_op(PQ_DROP_ID, 8'd0, 8'd99, 8'd0);
    n_checks++; if (drop_hit !== 1'b0 || count !== 3'd3) begin n_fail++;
      $display("FAIL drop_miss: got hit=%b cnt=%0d want 0/3", drop_hit, count);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (head_time !== exp_t[k]) begin n_fail++;
        $display("FAIL drop_order%0d: got %0d want %0d", k, head_time, exp_t[k]);
      end
      do_op(PQ_POP, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_empty_flush();
    do_op(PQ_POP, 8'd0, 8'd0, 8'd0);
    n_checks++; if (count !== 3'd0 || head_valid !== 1'b0 || evict_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_empty: got cnt=%0d head_v=%b ev=%b want 0/0/0",
               count, head_valid, evict_valid);
    end
    do_op(PQ_REPLACE, 8'd12, 8'd3, 8'd0);
    n_checks++; if (count !== 3'd1 || head_time !== 8'd12) begin n_fail++;
      $display("FAIL replace_empty: got cnt=%0d t=%0d want 1/12", count, head_time);
    end
    do_op(pq_op_e'(3'd6), 8'd1, 8'd1, 8'd0);
    n_checks++; if (count !== 3'd1 || head_time !== 8'd12) begin n_fail++;
      $display("FAIL undef_op: got cnt=%0d t=%0d want 1/12", count, head_time);
    end
    do_op(PQ_PUSH, 8'd13, 8'd9, 8'd0);
    do_op(PQ_PUSH, 8'd14, 8'd9, 8'd0);
    do_op(PQ_PUSH, 8'd11, 8'd4, 8'd0);
    do_op(PQ_DROP_ID, 8'd0, 8'd9, 8'd0);
    n_checks++; if (count !== 3'd3 || drop_hit !== 1'b1) begin n_fail++;
      $display("FAIL drop_dup: got cnt=%0d hit=%b want 3/1", count, drop_hit);
    end
    do_op(PQ_PUSH, 8'd90, 8'd5, 8'd0);
    do_op(PQ_FLUSH, 8'd0, 8'd0, 8'd0);
    n_checks++;
    if (count !== 3'd0 || empty !== 1'b1 || evict_valid !== 1'b0 || drop_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: got cnt=%0d empty=%b ev=%b hit=%b want 0/1/0/0",
               count, empty, evict_valid, drop_hit);
    end
  endtask

  task automatic test_random();
    logic [7:0] mt [DEPTH];
    logic [7:0] mid [DEPTH];
    logic [7:0] mpl [DEPTH];
    int         mn;
    int         pos;
    logic       exp_ev, exp_hit, do_ins;
    logic [7:0] ev_t, ev_id, t, idv, pl;
    pq_op_e     o;
    mn = 0;
    ev_t = '0; ev_id = '0;
    for (int it = 0; it < 80; it++) begin
      t   = 8'($urandom_range(0, 120));
      idv = 8'($urandom_range(0, 7));
      pl  = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 6))
        0, 1:    o = PQ_PUSH;
        2:       o = PQ_POP;
        3:       o = PQ_REPLACE;
        4:       o = PQ_DROP_ID;
        5:       o = PQ_FLUSH;
        default: o = PQ_NOP;
      endcase
      exp_ev = 1'b0; exp_hit = 1'b0; do_ins = 1'b0;
      if (o == PQ_REPLACE && mn > 0) begin
        for (int j = 0; j < mn - 1; j++) begin
          mt[j] = mt[j+1]; mid[j] = mid[j+1]; mpl[j] = mpl[j+1];
        end
        mn--;
        do_ins = 1'b1;
      end else if (o == PQ_PUSH || o == PQ_REPLACE) begin
        pos = mn;
        for (int k = mn - 1; k >= 0; k--) if (before8(t, mt[k])) pos = k;
        if (mn == DEPTH && pos == DEPTH) begin
          exp_ev = 1'b1; ev_t = t; ev_id = idv;
        end else begin
          if (mn == DEPTH) begin
            exp_ev = 1'b1; ev_t = mt[DEPTH-1]; ev_id = mid[DEPTH-1]; mn--;
          end
          do_ins = 1'b1;
        end
      end else if (o == PQ_POP && mn > 0) begin
        for (int j = 0; j < mn - 1; j++) begin
          mt[j] = mt[j+1]; mid[j] = mid[j+1]; mpl[j] = mpl[j+1];
        end
        mn--;
      end else if (o == PQ_DROP_ID) begin
        pos = -1;
        for (int k = mn - 1; k >= 0; k--) if (mid[k] == idv) pos = k;
        if (pos >= 0) begin
          for (int j = pos; j < mn - 1; j++) begin
            mt[j] = mt[j+1]; mid[j] = mid[j+1]; mpl[j] = mpl[j+1];
          end
          mn--;
          exp_hit = 1'b1;
        end
      end else if (o == PQ_FLUSH) begin
        mn = 0;
      end
      if (do_ins) begin
        pos = mn;
        for (int k = mn - 1; k >= 0; k--) if (before8(t, mt[k])) pos = k;
        for (int j = mn; j > pos; j--) begin
          mt[j] = mt[j-1]; mid[j] = mid[j-1]; mpl[j] = mpl[j-1];
        end
        mt[pos] = t; mid[pos] = idv; mpl[pos] = pl;
        mn++;
      end
      do_op(o, t, idv, pl);
      n_checks++;
      if (count !== 3'(mn) || head_valid !== (mn > 0) || evict_valid !== exp_ev ||
          drop_hit !== exp_hit) begin n_fail++;
        $display("FAIL rand%0d_ctl: got cnt=%0d hv=%b ev=%b hit=%b want %0d/%b/%b/%b",
                 it, count, head_valid, evict_valid, drop_hit, mn, mn > 0, exp_ev, exp_hit);
      end
      if (mn > 0) begin
        n_checks++;
        if (head_time !== mt[0] || head_id !== mid[0] || head_payload !== mpl[0]) begin
          n_fail++;
          $display("FAIL rand%0d_head: got t=%0d id=%0d p=%0d want %0d/%0d/%0d", it,
                   head_time, head_id, head_payload, mt[0], mid[0], mpl[0]);
        end
      end
      if (exp_ev) begin
        n_checks++; if (evict_time !== ev_t || evict_id !== ev_id) begin n_fail++;
          $display("FAIL rand%0d_evict: got t=%0d id=%0d want %0d/%0d",
                   it, evict_time, evict_id, ev_t, ev_id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sorted_push_pop();
    test_wrap();
    test_full_evict();
    test_replace_drop();
    test_empty_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
